dsp_frame_loader: RTL
=====================

DSP_FRAME_LOADER -- requirements
Module: dsp_frame_loader

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, frames per DSP column (strobe width).
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, bits per frame word (per tile row).
REQ-003 SHALL have port UserCLK  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin loading a full DSP tile pair.
REQ-006 SHALL have port abort  input  1  cancel an in-progress load.
REQ-007 SHALL have port in_data  input  FrameBitsPerRow  bitstream word.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-010 SHALL have port FrameData_top  output  FrameBitsPerRow  row data for upper tile (X0Y0).
REQ-011 SHALL have port FrameData_bot  output  FrameBitsPerRow  row data for lower tile (X0Y1).
REQ-012 SHALL have port FrameStrobe  output  MaxFramesPerCol  one-hot frame strobe to lower tile (chains upward).
REQ-013 SHALL have ports busy, done, err  output  1 each  load active / one-cycle completion pulse / sticky checksum error.

Function
REQ-014 SHALL implement states IDLE, LOAD_TOP, LOAD_BOT, STROBE, GAP, DONE (plus LOAD_CRC, see REQ-027).
REQ-015 IDLE: start=1 -> LOAD_TOP, frame counter f=0, err cleared; start ignored in every other state.
REQ-016 in_ready SHALL be 1 only in LOAD_TOP, LOAD_BOT (and LOAD_CRC); a word transfers when in_valid&in_ready.
REQ-017 LOAD_TOP: on transfer, FrameData_top <= in_data (visible next cycle), -> LOAD_BOT; without transfer, stay.
REQ-018 LOAD_BOT: on transfer, FrameData_bot <= in_data, -> STROBE.
REQ-019 STROBE: FrameStrobe = one-hot bit f for exactly one cycle, -> GAP; FrameStrobe SHALL be all-zero in every other state.
REQ-020 GAP: strobe low, FrameData_* held; if f==MaxFramesPerCol-1 -> DONE (or LOAD_CRC), else f<=f+1, -> LOAD_TOP.
REQ-021 FrameData_top/bot SHALL hold their last value until overwritten (stable during STROBE and GAP).
REQ-022 DONE: done=1 for one cycle, -> IDLE; busy=1 in every state except IDLE.
REQ-023 Minimum throughput SHALL be 4 cycles per frame (2 transfers, STROBE, GAP); in_valid stalls extend LOAD_* only.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle, strobe low, no done pulse, f=0; abort has priority over a simultaneous transfer (word not consumed in the sense of REQ-017/018; in_ready still 1 that cycle).
REQ-025 abort in IDLE and start together with abort SHALL be ignored (stay IDLE).

Reset
REQ-026 reset SHALL force IDLE, f=0, FrameData_top=FrameData_bot=0, FrameStrobe=0, in_ready=0, busy=0, done=0, err=0; reset mid-load discards progress with no strobe in the following cycle.

Configuration
REQ-027 With DSP_FRAME_LOADER_CRC_EN defined: GAP after last frame -> LOAD_CRC; loader keeps running XOR of all 2*MaxFramesPerCol accepted words; in LOAD_CRC one more word is accepted, err<=1 if it differs from the XOR, -> DONE; err sticky until next start or reset; done pulses regardless of err.
REQ-028 Without DSP_FRAME_LOADER_CRC_EN: no LOAD_CRC state, no XOR register, err tied 0.

Structure
REQ-029 Shared package SHALL hold the state enumeration and frame-counter width constant ($clog2(MaxFramesPerCol)).
REQ-030 One sub-module, dsp_frame_strobe_dec (counter f + enable -> one-hot FrameStrobe), SHALL be instantiated; all else flat.

Verification
REQ-031 Reset then start, in_valid always 1, words 0x1000_0000+i -> frame 0 strobe bit0 at cycle 3 after start, done at cycle 81, data top/bot = word 2f / 2f+1 at each strobe.
REQ-032 in_valid low 5 cycles during frame 7 LOAD_BOT -> in_ready held, no strobe until transfer, FrameStrobe bit7 exactly once.
REQ-033 abort asserted in STROBE of frame 3 -> next cycle IDLE, busy=0, FrameStrobe=0, no done; fresh start restarts at bit0.
REQ-034 start pulsed during busy (frame 10) -> ignored, sequence and f unchanged.
REQ-035 CRC_EN: correct XOR trailer -> done=1, err=0; trailer ^ 0x1 -> done=1, err=1 held until next start.
REQ-036 reset asserted during frame 12 LOAD_TOP -> all outputs zero next cycle, in_ready=0.

Source files
------------

// File: rtl/dsp_frame_loader_pkg.sv
// Shared types and constants for the DSP frame loader.
// Optional feature: define DSP_FRAME_LOADER_CRC_EN to add the XOR trailer check
// (extra LOAD_CRC state, running XOR register, sticky err flag).
package dsp_frame_loader_pkg;

  localparam int DefaultMaxFramesPerCol = 20;
  localparam int DefaultFrameBitsPerRow = 32;

  // Counter width able to index every frame of a column (never zero bits wide).
  function automatic int frame_cnt_w(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

  localparam int FrameCntW = frame_cnt_w(DefaultMaxFramesPerCol);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_TOP = 3'd1,
    LOAD_BOT = 3'd2,
    STROBE   = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5
`ifdef DSP_FRAME_LOADER_CRC_EN
    ,
    LOAD_CRC = 3'd6
`endif
  } state_t;

endpackage

// File: rtl/dsp_frame_strobe_dec.sv
// Frame counter to one-hot frame strobe decoder for one DSP column.
module dsp_frame_strobe_dec
  import dsp_frame_loader_pkg::*;
#(
  parameter int Frames = DefaultMaxFramesPerCol,
  parameter int CntW   = FrameCntW
) (
  input  logic [CntW-1:0]   f,
  input  logic              en,
  output logic [Frames-1:0] strobe
);

  // Raise exactly the strobe bit selected by f while enabled.
  always_comb begin
    // NOTE: default assignment first so every path drives strobe and no latch is inferred.
    strobe = '0;
    for (int i = 0; i < Frames; i++) begin
      if (en && (f == CntW'(i))) strobe[i] = 1'b1;
    end
  end

endmodule

// File: rtl/dsp_frame_loader.sv
// DSP tile-pair frame loader: streams two words per frame (upper tile, then
// lower tile), strobes the frame, then idles one gap cycle before the next.
// Optional feature: define DSP_FRAME_LOADER_CRC_EN to require an XOR trailer
// word after the last frame; a mismatch sets the sticky err output.
module dsp_frame_loader
  import dsp_frame_loader_pkg::*;
#(
  parameter int MaxFramesPerCol = DefaultMaxFramesPerCol,
  parameter int FrameBitsPerRow = DefaultFrameBitsPerRow
) (
  input  logic                       UserCLK,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [FrameBitsPerRow-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FrameBitsPerRow-1:0] FrameData_top,
  output logic [FrameBitsPerRow-1:0] FrameData_bot,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int FW = frame_cnt_w(MaxFramesPerCol);
  localparam logic [FW-1:0] LastFrame = FW'(MaxFramesPerCol - 1);

  state_t        state;
  logic [FW-1:0] f;
  logic          xfer;

  assign xfer = in_valid && in_ready;

  // Handshake and status outputs are pure decodes of the state register.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      LOAD_TOP, LOAD_BOT: in_ready = 1'b1;
`ifdef DSP_FRAME_LOADER_CRC_EN
      LOAD_CRC:           in_ready = 1'b1;
`endif
      default:            in_ready = 1'b0;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  dsp_frame_strobe_dec #(
    .Frames(MaxFramesPerCol),
    .CntW  (FW)
  ) u_strobe_dec (
    .f     (f),
    .en    (state == STROBE),
    .strobe(FrameStrobe)
  );

  // Main sequencer: abort beats everything except reset; a word aborted in the
  // same cycle it is offered is not captured.
  always_ff @(posedge UserCLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state         <= IDLE;
      f             <= '0;
      FrameData_top <= '0;
      FrameData_bot <= '0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;
      f     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state <= LOAD_TOP;
            f     <= '0;
          end
        end
        LOAD_TOP: begin
          if (xfer) begin
            FrameData_top <= in_data;
            state         <= LOAD_BOT;
          end
        end
        LOAD_BOT: begin
          if (xfer) begin
            FrameData_bot <= in_data;
            state         <= STROBE;
          end
        end
        STROBE: state <= GAP;
        GAP: begin
          if (f == LastFrame) begin
`ifdef DSP_FRAME_LOADER_CRC_EN
            state <= LOAD_CRC;
`else
            state <= DONE;
`endif
          end else begin
            f     <= f + FW'(1);
            state <= LOAD_TOP;
          end
        end
`ifdef DSP_FRAME_LOADER_CRC_EN
        LOAD_CRC: begin
          if (xfer) state <= DONE;
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DSP_FRAME_LOADER_CRC_EN
  logic [FrameBitsPerRow-1:0] crc;
  logic                       err_q;

  // Running XOR of all frame words; trailer compare sets the sticky error.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      crc   <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE) begin
      if (start && !abort) begin
        crc   <= '0;
        err_q <= 1'b0;
      end
    end else if (xfer && !abort) begin
      if (state == LOAD_CRC) err_q <= (in_data != crc);
      else                   crc   <= crc ^ in_data;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
